// File: rtl/cc_serializer_pkg.sv
// Shared types and sizing helpers for the cache-line serializer.
// Pure declarations: no latency, no flow control.
package cc_serializer_pkg;

  localparam int DEF_DATA_W = 64;
  localparam int DEF_LINE_W = 512;

  typedef enum logic {
    IDLE,
    STREAM
  } ser_state_e;

  function automatic int beats_of(input int line_w, input int data_w);
    return line_w / data_w;
  endfunction

endpackage

// File: rtl/cc_beat_select.sv
// Combinational pick of word[(ofs+cnt) mod BEATS] from a line, word 0 in the MSBs.
// Zero latency; no flow control of its own.
module cc_beat_select #(
  parameter int DATA_W = 64,
  parameter int LINE_W = 512,
  localparam int BEATS = LINE_W / DATA_W,
  localparam int OFS_W = $clog2(BEATS)
) (
  input  logic [LINE_W-1:0] line_i,
  input  logic [OFS_W-1:0]  ofs_i,
  input  logic [OFS_W-1:0]  cnt_i,
  output logic [DATA_W-1:0] word_o
);

  logic [DATA_W-1:0] words [BEATS];
  logic [OFS_W-1:0]  idx;

  for (genvar g = 0; g < BEATS; g++) begin : g_split
    assign words[g] = line_i[LINE_W-1-g*DATA_W -: DATA_W];
  end

  // BEATS is a power of two, so the OFS_W-bit sum wraps exactly mod BEATS.
  assign idx    = ofs_i + cnt_i;
  assign word_o = words[idx];

endmodule

// File: rtl/cc_line_serializer.sv
// Critical-word-first line-to-beat serializer; first beat 1 cycle after FIFO non-empty, 1 beat/cycle.
// Registered R output holds under rready_i=0; CC_SER_ID_EN adds the rid_o passthrough.
module cc_line_serializer
  import cc_serializer_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LINE_W = DEF_LINE_W,
`ifdef CC_SER_ID_EN
  parameter int ID_W = 4,
  localparam int ID_BITS = ID_W,
`else
  localparam int ID_BITS = 0,
`endif
  localparam int BEATS   = beats_of(LINE_W, DATA_W),
  localparam int OFS_W   = $clog2(BEATS),
  localparam int ENTRY_W = ID_BITS + OFS_W + LINE_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fifo_empty_i,
  input  logic [ENTRY_W-1:0] fifo_rdata_i,
  output logic               fifo_rden_o,
  output logic [DATA_W-1:0]  rdata_o,
  output logic               rlast_o,
  output logic               rvalid_o,
  input  logic               rready_i
`ifdef CC_SER_ID_EN
  ,
  output logic [ID_W-1:0]    rid_o
`endif
);

  ser_state_e        state_q, state_d;
  logic [OFS_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rlast_q, rlast_d;
  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] sel_word;
  logic              load;
  logic              last_beat;

`ifdef CC_SER_ID_EN
  logic [ID_W-1:0] rid_q, rid_d;
`endif

  cc_beat_select #(
    .DATA_W (DATA_W),
    .LINE_W (LINE_W)
  ) u_sel (
    .line_i (fifo_rdata_i[LINE_W-1:0]),
    .ofs_i  (fifo_rdata_i[LINE_W +: OFS_W]),
    .cnt_i  (cnt_q),
    .word_o (sel_word)
  );

  assign load      = !fifo_empty_i && (!rvalid_q || rready_i);
  assign last_beat = (cnt_q == OFS_W'(BEATS-1));
  // Pop together with loading the last beat so the next line is already at the head.
  assign fifo_rden_o = rst_n && load && last_beat;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    rlast_d  = rlast_q;
    rvalid_d = rvalid_q;
`ifdef CC_SER_ID_EN
    rid_d    = rid_q;
`endif
    if (load) begin
      rdata_d  = sel_word;
      rlast_d  = last_beat;
      rvalid_d = 1'b1;
      cnt_d    = cnt_q + OFS_W'(1);
`ifdef CC_SER_ID_EN
      rid_d    = fifo_rdata_i[LINE_W+OFS_W +: ID_W];
`endif
    end else if (rvalid_q && rready_i) begin
      rvalid_d = 1'b0;
      rlast_d  = 1'b0;
    end
    case (state_q)
      IDLE:    if (load) state_d = STREAM;
      STREAM:  if (load && last_beat) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rdata_q  <= '0;
      rlast_q  <= 1'b0;
      rvalid_q <= 1'b0;
`ifdef CC_SER_ID_EN
      rid_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      rlast_q  <= rlast_d;
      rvalid_q <= rvalid_d;
`ifdef CC_SER_ID_EN
      rid_q    <= rid_d;
`endif
    end
  end

  assign rdata_o  = rdata_q;
  assign rlast_o  = rlast_q;
  assign rvalid_o = rvalid_q;
`ifdef CC_SER_ID_EN
  assign rid_o    = rid_q;
`endif

endmodule

// File: tb/tb_cc_line_serializer.sv
// Bench for cc_line_serializer: FIFO and beat-order model built from queues, per-cycle compare.
// Builds with or without CC_SER_ID_EN (128-bit beats when defined).
module tb_cc_line_serializer;
`ifdef CC_SER_ID_EN
  localparam int DW  = 128;
  localparam int IDB = 4;
`else
  localparam int DW  = 64;
  localparam int IDB = 0;
`endif
  localparam int LW    = 512;
  localparam int BEATS = LW / DW;
  localparam int OW    = $clog2(BEATS);
  localparam int IW    = 4;
  localparam int EW    = IDB + OW + LW;

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
    logic [IW-1:0] id;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [EW-1:0] fifo_rdata = '0;
  logic          rready = 1'b1;
  logic          fifo_rden;
  logic [DW-1:0] rdata;
  logic          rlast;
  logic          rvalid;
`ifdef CC_SER_ID_EN
  logic [IW-1:0] rid;
`endif

  cc_line_serializer #(
    .DATA_W (DW),
`ifdef CC_SER_ID_EN
    .ID_W   (IW),
`endif
    .LINE_W (LW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fifo_empty_i (fifo_empty),
    .fifo_rdata_i (fifo_rdata),
    .fifo_rden_o  (fifo_rden),
    .rdata_o      (rdata),
    .rlast_o      (rlast),
    .rvalid_o     (rvalid),
    .rready_i     (rready)
`ifdef CC_SER_ID_EN
    ,
    .rid_o        (rid)
`endif
  );

  always #5 clk = ~clk;

  logic [EW-1:0] fifo_q[$];
  beat_t         exp_q[$];
  int            n_chk = 0;
  int            n_fail = 0;
  int            cyc = 0;
  int            rden_seen = 0;
  int            rden_done = 0;
  int            acc_n = 0;
  logic [DW-1:0] acc_d [64];
  logic          acc_l [64];
  logic [IW-1:0] acc_id[64];
  int            acc_c [64];
  logic [DW-1:0] last_dat;
  logic          have_last = 1'b0;
  logic          prev_rden = 1'b0;
  logic          prev_stall = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] wrd(input int tag, input int k);
    return DW'(tag * 256 + k);
  endfunction

  task automatic upd();
    fifo_empty = (fifo_q.size() == 0);
    if (fifo_q.size() == 0) fifo_rdata = '0;
    else fifo_rdata = fifo_q[0];
  endtask

  // Expected beats of one entry, derived straight from its fields.
  task automatic expect_entry(input logic [EW-1:0] e);
    beat_t b;
    int    ofs;
    ofs = int'(e[LW +: OW]);
    for (int k = 0; k < BEATS; k++) begin
      b.d = e[LW-1-((ofs+k)%BEATS)*DW -: DW];
      b.l = (k == BEATS-1);
`ifdef CC_SER_ID_EN
      b.id = e[LW+OW +: IW];
`else
      b.id = '0;
`endif
      exp_q.push_back(b);
    end
  endtask

  task automatic push(input int ofs, input int tag, input logic [IW-1:0] id);
    logic [LW-1:0] line;
    logic [EW-1:0] e;
    for (int k = 0; k < BEATS; k++) line[LW-1-k*DW -: DW] = wrd(tag, k);
`ifdef CC_SER_ID_EN
    e = {id, OW'(ofs % BEATS), line};
`else
    e = {OW'(ofs % BEATS), line};
    if (id != '0) e = e;
`endif
    fifo_q.push_back(e);
    expect_entry(e);
    upd();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    while (rden_done < rden_seen) begin
      rden_done++;
      if (fifo_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL pop_empty: got pop, want no pop");
      end else begin
        void'(fifo_q.pop_front());
      end
    end
    upd();
  endtask

  task automatic drain(input string nm);
    int b = 0;
    while ((exp_q.size() != 0 || fifo_q.size() != 0) && b < 200) begin
      step();
      b++;
    end
    repeat (2) step();
    chk({nm, "_drain"}, 128'(b < 200), 128'(1));
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_rvalid", 128'(rvalid), 128'(0));
      chk("rst_rlast", 128'(rlast), 128'(0));
      chk("rst_rdata", 128'(rdata), 128'(0));
      chk("rst_rden", 128'(fifo_rden), 128'(0));
      have_last  = 1'b0;
      prev_rden  = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (prev_rden) chk("rden_with_last", 128'({rvalid, rlast}), 128'(2'b11));
      if (prev_stall) chk("stall_hold_vld", 128'(rvalid), 128'(1));
      prev_rden  = fifo_rden;
      prev_stall = rvalid && !rready;
      if (fifo_rden) rden_seen++;
      if (rvalid) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL extra_beat: got %0h, want no beat", rdata);
        end else begin
          chk("beat_dat", 128'(rdata), 128'(exp_q[0].d));
          chk("beat_last", 128'(rlast), 128'(exp_q[0].l));
`ifdef CC_SER_ID_EN
          chk("beat_id", 128'(rid), 128'(exp_q[0].id));
`endif
          if (rready) begin
            if (acc_n < 64) begin
              acc_d[acc_n] = rdata;
              acc_l[acc_n] = rlast;
              acc_c[acc_n] = cyc;
`ifdef CC_SER_ID_EN
              acc_id[acc_n] = rid;
`else
              acc_id[acc_n] = '0;
`endif
            end
            acc_n++;
            void'(exp_q.pop_front());
            last_dat  = rdata;
            have_last = 1'b1;
          end
        end
      end else if (have_last) begin
        chk("idle_hold_dat", 128'(rdata), 128'(last_dat));
        chk("idle_rlast", 128'(rlast), 128'(0));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    int b;
    logic [EW-1:0] e;
    rready = 1'b1;
    upd();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: ofs 0, words 0..BEATS-1, 1-cycle latency
    acc_n = 0; r0 = rden_done;
    push(0, 0, 4'h1);
    step();
    chk("t1_latency", 128'(rvalid), 128'(1));
    drain("t1");
    chk("t1_beats", 128'(acc_n), 128'(BEATS));
    chk("t1_rden", 128'(rden_done - r0), 128'(1));
    chk("t1_first", 128'(acc_d[0]), 128'(0));
    chk("t1_lastflag", 128'(acc_l[BEATS-1]), 128'(1));
    chk("t1_notlast", 128'(acc_l[BEATS-2]), 128'(0));
`ifndef CC_SER_ID_EN
    chk("t1_w7", 128'(acc_d[7]), 128'(64'h7));
`endif

    // 2: ofs 5, wrap through word 0
    acc_n = 0;
    push(5, 0, 4'h2);
    drain("t2");
    chk("t2_beats", 128'(acc_n), 128'(BEATS));
`ifndef CC_SER_ID_EN
    chk("t2_first", 128'(acc_d[0]), 128'(64'h5));
    chk("t2_wrap", 128'(acc_d[3]), 128'(64'h0));
    chk("t2_final", 128'(acc_d[7]), 128'(64'h4));
    chk("t2_final_last", 128'(acc_l[7]), 128'(1));
`endif

    // 3: ofs 2, stall 3 cycles on the third beat
    acc_n = 0;
    push(2, 1, 4'h3);
    b = 0;
    while (acc_n < 2 && b < 50) begin step(); b++; end
    rready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t3_stall_vld", 128'(rvalid), 128'(1));
      chk("t3_stall_dat", 128'(rdata), 128'(wrd(1, (2+2) % BEATS)));
    end
    rready = 1'b1;
    drain("t3");
    chk("t3_beats", 128'(acc_n), 128'(BEATS));
`ifndef CC_SER_ID_EN
    chk("t3_held", 128'(acc_d[2]), 128'(64'h104));
    chk("t3_resume", 128'(acc_d[3]), 128'(64'h105));
`endif

    // 4: two queued lines, gap-free
    acc_n = 0; r0 = rden_done;
    push(0, 2, 4'h4);
    push(3, 3, 4'h5);
    drain("t4");
    chk("t4_beats", 128'(acc_n), 128'(2*BEATS));
    chk("t4_rden", 128'(rden_done - r0), 128'(2));
    chk("t4_second_first", 128'(acc_d[BEATS]), 128'(wrd(3, 3 % BEATS)));
    chk("t4_gapfree", 128'(acc_c[2*BEATS-1] - acc_c[0]), 128'(2*BEATS-1));

    // 5: async reset mid-line, replay from critical word
    acc_n = 0; r0 = rden_done;
    push(1, 4, 4'h6);
    b = 0;
    while (acc_n < 4 && b < 50) begin step(); b++; end
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_vld", 128'(rvalid), 128'(0));
    chk("t5_rst_dat", 128'(rdata), 128'(0));
    chk("t5_rst_rden", 128'(fifo_rden), 128'(0));
    exp_q.delete();
    foreach (fifo_q[i]) begin
      e = fifo_q[i];
      expect_entry(e);
    end
    repeat (2) step();
    chk("t5_not_popped", 128'(fifo_q.size()), 128'(1));
    rst_n = 1'b1;
    acc_n = 0;
    drain("t5");
    chk("t5_beats", 128'(acc_n), 128'(BEATS));
    chk("t5_replay", 128'(acc_d[0]), 128'(wrd(4, 1)));
    chk("t5_rden", 128'(rden_done - r0), 128'(1));

`ifdef CC_SER_ID_EN
    // 6: 128-bit beats, id A, ofs 3
    acc_n = 0;
    push(3, 5, 4'hA);
    drain("t6");
    chk("t6_beats", 128'(acc_n), 128'(4));
    chk("t6_b0", 128'(acc_d[0]), 128'(128'h503));
    chk("t6_b1", 128'(acc_d[1]), 128'(128'h500));
    chk("t6_b3", 128'(acc_d[3]), 128'(128'h502));
    chk("t6_last", 128'(acc_l[3]), 128'(1));
    for (int k = 0; k < 4; k++) chk("t6_id", 128'(acc_id[k]), 128'(4'hA));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
